// File: rtl/digit_seq_pkg.sv
// Shared types and constants for the digit update sequencer.
// Configuration macro used by the sequencer: DIGIT_SEQ_BLANK_EN (leading-zero blanking).
package digit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    localparam int         BCD_W         = 4;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam logic [3:0] BLANK_CODE    = 4'hF;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic longint unsigned max_value(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Combinational double-dabble correction: every BCD nibble that is >= 5 gets +3
// so that the following left shift carries correctly into the next decade.
module bcd_add3_stage
    import digit_seq_pkg::*;
#(
    parameter int W = 12
)(
    input  logic [W-1:0] bcd_in,
    output logic [W-1:0] bcd_out
);

    // Nibbles never exceed 9 here, so +3 stays inside the nibble.
    always_comb begin
        bcd_out = bcd_in;
        for (int i = 0; i < W / BCD_W; i++) begin
            if (bcd_in[i*BCD_W +: BCD_W] >= 4'd5) begin
                bcd_out[i*BCD_W +: BCD_W] = bcd_in[i*BCD_W +: BCD_W] + 4'd3;
            end else begin
                bcd_out[i*BCD_W +: BCD_W] = bcd_in[i*BCD_W +: BCD_W];
            end
        end
    end

endmodule

// File: rtl/digit_update_sequencer.sv
// Binary-to-BCD sequencer writing one digit per cycle (LSD first) to 4-bit PIO digit slaves.
// Optional leading-zero blanking is enabled by defining DIGIT_SEQ_BLANK_EN.
module digit_update_sequencer
    import digit_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int VALUE_W    = 10
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] dig_chipselect,
    output logic [1:0]            dig_address,
    output logic                  dig_write_n,
    output logic [31:0]           dig_writedata
);

    localparam int DIG_W   = BCD_W * NUM_DIGITS;
    // Guard nibbles hold the full decimal expansion of any VALUE_W-bit value, so any
    // non-zero guard bit after conversion means the value does not fit in NUM_DIGITS.
    localparam int GUARD_W = BCD_W * ((VALUE_W + 2) / 3);
    localparam int TOT_W   = DIG_W + GUARD_W;
    localparam int CNT_W   = $clog2(VALUE_W + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] CS_ONE   = NUM_DIGITS'(1'b1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(VALUE_W);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    seq_state_t                state_q, state_d;
    logic [VALUE_W-1:0]        bin_q, bin_d;
    logic [TOT_W-1:0]          bcd_q, bcd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DIG_W-1:0]          digits_q, digits_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;
    logic [NUM_DIGITS-1:0]     cs_q, cs_d;
    logic                      wr_n_q, wr_n_d;
    logic [31:0]               wdata_q, wdata_d;

    logic [TOT_W-1:0]          bcd_adj_s;
    logic [TOT_W+VALUE_W-1:0]  shift_s;
    logic [TOT_W-1:0]          final_bcd_s;
    logic                      ovf_s;
    logic [DIG_W-1:0]          codes_s;

    bcd_add3_stage #(
        .W (TOT_W)
    ) u_add3 (
        .bcd_in  (bcd_q),
        .bcd_out (bcd_adj_s)
    );

    // One double-dabble step; on the last CONVERT cycle this is the finished BCD value.
    always_comb begin
        shift_s     = {bcd_adj_s, bin_q} << 1;
        final_bcd_s = shift_s[TOT_W+VALUE_W-1:VALUE_W];
    end

    // Digit codes for the write phase, prepared from the final BCD so they are registered before WRITE.
    always_comb begin
        ovf_s = |final_bcd_s[TOT_W-1:DIG_W];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf_s) begin
                codes_s[i*BCD_W +: BCD_W] = 4'd9;
            end else begin
                codes_s[i*BCD_W +: BCD_W] = final_bcd_s[i*BCD_W +: BCD_W];
            end
        end
`ifdef DIGIT_SEQ_BLANK_EN
        begin
            logic lead_s;
            lead_s = 1'b1;
            // Walk down from the MSD; digit 0 is never blanked.
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (lead_s && (codes_s[i*BCD_W +: BCD_W] == 4'd0)) begin
                    codes_s[i*BCD_W +: BCD_W] = BLANK_CODE;
                end else begin
                    lead_s = 1'b0;
                end
            end
        end
`endif
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        digits_d   = digits_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        cs_d       = '0;
        wr_n_d     = 1'b1;
        wdata_d    = 32'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONVERT;
                    bin_d   = value_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            CONVERT: begin
                bin_d = shift_s[VALUE_W-1:0];
                bcd_d = final_bcd_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = WRITE;
                    idx_d      = '0;
                    digits_d   = codes_s;
                    overflow_d = ovf_s;
                    cs_d       = CS_ONE;
                    wr_n_d     = 1'b0;
                    wdata_d    = {{(32-BCD_W){1'b0}}, codes_s[BCD_W-1:0]};
                end else begin
                    state_d = CONVERT;
                end
            end
            WRITE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WRITE;
                    idx_d   = idx_q + IDX_W'(1);
                    cs_d    = CS_ONE << idx_d;
                    wr_n_d  = 1'b0;
                    wdata_d = {{(32-BCD_W){1'b0}}, digits_q[BCD_W*idx_d +: BCD_W]};
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            digits_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            cs_q       <= '0;
            wr_n_q     <= 1'b1;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            digits_q   <= digits_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            cs_q       <= cs_d;
            wr_n_q     <= wr_n_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign dig_chipselect = cs_q;
    assign dig_address    = PIO_DATA_ADDR;
    assign dig_write_n    = wr_n_q;
    assign dig_writedata  = wdata_q;

endmodule

// File: tb/tb_digit_update_sequencer.sv
// Self-checking bench for digit_update_sequencer: constant vector table, hand-written
// corner sequences and random values checked against a decimal-arithmetic model.
module tb_digit_update_sequencer;

    localparam int ND  = 3;
    localparam int VW  = 10;
    localparam int LAT = VW + ND;

    typedef struct {
        logic [VW-1:0]   value;
        logic [ND*4-1:0] codes;
        logic            ovf;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [VW-1:0]   value_in;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [ND-1:0]   dig_chipselect;
    logic [1:0]      dig_address;
    logic            dig_write_n;
    logic [31:0]     dig_writedata;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[9];

    always #5 clk = ~clk;

    digit_update_sequencer #(
        .NUM_DIGITS (ND),
        .VALUE_W    (VW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .value_in       (value_in),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .dig_chipselect (dig_chipselect),
        .dig_address    (dig_address),
        .dig_write_n    (dig_write_n),
        .dig_writedata  (dig_writedata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] out_vec();
        return {busy, done, dig_chipselect, dig_write_n, dig_address, dig_writedata};
    endfunction

    // Expected bus picture for the cycle after edge t0+c (start sampled at edge t0).
    function automatic logic [39:0] exp_vec(input int c, input logic [ND*4-1:0] codes);
        logic          busy_e, done_e, wr_e;
        logic [ND-1:0] cs_e;
        logic [31:0]   wd_e;
        busy_e = (c <= LAT);
        done_e = (c == LAT);
        if (c >= VW && c < LAT) begin
            cs_e = 3'b001 << (c - VW);
            wr_e = 1'b0;
            wd_e = {28'd0, codes[(c-VW)*4 +: 4]};
        end else begin
            cs_e = 3'b000;
            wr_e = 1'b1;
            wd_e = 32'd0;
        end
        return {busy_e, done_e, cs_e, wr_e, 2'b00, wd_e};
    endfunction

    // Reference: plain decimal arithmetic, returns {overflow, digit codes}.
    function automatic logic [ND*4:0] model(input int unsigned v);
        int unsigned     lim, pw;
        int              msd;
        logic [3:0]      d[ND];
        logic [ND*4-1:0] c;
        lim = 1;
        for (int i = 0; i < ND; i++) lim = lim * 10;
        if (v >= lim) begin
            for (int i = 0; i < ND; i++) c[i*4 +: 4] = 4'd9;
            return {1'b1, c};
        end
        pw  = 1;
        msd = 0;
        for (int i = 0; i < ND; i++) begin
            d[i] = 4'((v / pw) % 10);
            if (d[i] != 4'd0) msd = i;
            pw = pw * 10;
        end
        for (int i = 0; i < ND; i++) begin
`ifdef DIGIT_SEQ_BLANK_EN
            c[i*4 +: 4] = (i > msd) ? 4'hF : d[i];
`else
            c[i*4 +: 4] = (msd >= 0) ? d[i] : 4'd0;
`endif
        end
        return {1'b0, c};
    endfunction

    // Called mid-cycle while the DUT is idle; returns at the negedge of the first IDLE cycle.
    task automatic run_seq(input string tag, input logic [VW-1:0] v, input logic [ND*4-1:0] codes,
                           input logic ovf, input bit poke);
        start    = 1'b1;
        value_in = v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        value_in = VW'($urandom);
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            check($sformatf("%s v=%0d cyc%0d", tag, v, c), {24'd0, out_vec()}, {24'd0, exp_vec(c, codes)});
            if (c == LAT) check($sformatf("%s v=%0d overflow", tag, v), {63'd0, overflow}, {63'd0, ovf});
            if (poke && c == 3) begin
                start    = 1'b1;
                value_in = VW'($urandom);
            end
            if (c < LAT + 1) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle%0d", tag, i), {24'd0, out_vec()}, {24'd0, exp_vec(LAT + 1, 12'h000)});
        end
    endtask

    initial begin
        logic [ND*4:0] r;
        logic [VW-1:0] v;

`ifdef DIGIT_SEQ_BLANK_EN
        tbl[0] = '{10'd987,  12'h987, 1'b0};
        tbl[1] = '{10'd5,    12'hFF5, 1'b0};
        tbl[2] = '{10'd0,    12'hFF0, 1'b0};
        tbl[3] = '{10'd42,   12'hF42, 1'b0};
        tbl[4] = '{10'd999,  12'h999, 1'b0};
        tbl[5] = '{10'd1000, 12'h999, 1'b1};
        tbl[6] = '{10'd100,  12'h100, 1'b0};
        tbl[7] = '{10'd10,   12'hF10, 1'b0};
        tbl[8] = '{10'd1023, 12'h999, 1'b1};
`else
        tbl[0] = '{10'd987,  12'h987, 1'b0};
        tbl[1] = '{10'd5,    12'h005, 1'b0};
        tbl[2] = '{10'd0,    12'h000, 1'b0};
        tbl[3] = '{10'd42,   12'h042, 1'b0};
        tbl[4] = '{10'd999,  12'h999, 1'b0};
        tbl[5] = '{10'd1000, 12'h999, 1'b1};
        tbl[6] = '{10'd100,  12'h100, 1'b0};
        tbl[7] = '{10'd10,   12'h010, 1'b0};
        tbl[8] = '{10'd1023, 12'h999, 1'b1};
`endif

        reset    = 1'b1;
        start    = 1'b0;
        value_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {24'd0, out_vec()}, {24'd0, exp_vec(LAT + 1, 12'h000)});
        check("reset overflow", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        idle_check("post-reset", 2);

        for (int k = 0; k < 9; k++) begin
            run_seq("table", tbl[k].value, tbl[k].codes, tbl[k].ovf, 1'b0);
            idle_check("table gap", 2);
        end

        // Reset sampled at edge t0+6 (mid-CONVERT); overflow was left high by 1023.
        start    = 1'b1;
        value_in = 10'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset outputs", {24'd0, out_vec()}, {24'd0, exp_vec(LAT + 1, 12'h000)});
        check("midreset overflow", {63'd0, overflow}, 64'd0);
        idle_check("midreset quiet", LAT + 2);
        r = model(42);
        run_seq("after-reset", 10'd42, r[ND*4-1:0], r[ND*4], 1'b0);
        idle_check("after-reset gap", 1);

        // Second start while busy must be ignored.
        run_seq("poke", 10'd987, tbl[0].codes, 1'b0, 1'b1);
        idle_check("poke tail", LAT + 2);

        // Back-to-back: second start in the first IDLE cycle.
        r = model(314);
        run_seq("b2b-a", 10'd314, r[ND*4-1:0], r[ND*4], 1'b0);
        r = model(271);
        run_seq("b2b-b", 10'd271, r[ND*4-1:0], r[ND*4], 1'b0);
        idle_check("b2b gap", 1);

        for (int k = 0; k < 24; k++) begin
            v = VW'($urandom_range(1023, 0));
            r = model(int'(v));
            run_seq("rand", v, r[ND*4-1:0], r[ND*4], 1'b0);
            if (k % 3 != 0) idle_check("rand gap", int'($urandom_range(2, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
